// File: rtl/led_walker.sv
// Single-LED walker stepped by an external tick strobe; supports wrap-around
// and bounce motion with an optional dwell at each end of the bar.
module led_walker #(
    parameter int N_LEDS = 8,
    parameter int DWELL  = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_tick,
    input  logic                      i_en,
    input  logic                      i_bounce,
    output logic [N_LEDS-1:0]         o_leds,
    output logic [$clog2(N_LEDS)-1:0] o_pos,
    output logic                      o_dir,
    output logic                      o_end
);

    localparam int PW = $clog2(N_LEDS);
    localparam int CW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
    localparam logic [PW-1:0]     P_TOP    = PW'(N_LEDS - 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(DWELL);
    localparam logic [N_LEDS-1:0] ONE_HOT0 = {{(N_LEDS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        RUN_UP    = 2'd0,
        RUN_DOWN  = 2'd1,
        DWELL_TOP = 2'd2,
        DWELL_BOT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               end_q, end_d;
    logic [N_LEDS-1:0]  leds_q, leds_d;
    logic               dir_q, dir_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= RUN_UP;
            pos_q   <= '0;
            cnt_q   <= '0;
            end_q   <= 1'b0;
            leds_q  <= ONE_HOT0;
            dir_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            end_q   <= end_d;
            leds_q  <= leds_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        end_d   = 1'b0;
        if (i_tick && i_en) begin
            if (!i_bounce) begin
                state_d = RUN_UP;
                cnt_d   = '0;
                if (pos_q == P_TOP) begin
                    pos_d = '0;
                    end_d = 1'b1;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end else begin
                case (state_q)
                    RUN_UP: begin
                        // Already at the top (e.g. after a mode switch) counts as landing.
                        if (pos_q != P_TOP) pos_d = pos_q + 1'b1;
                        if (pos_d == P_TOP) begin
                            end_d   = 1'b1;
                            state_d = (DWELL > 0) ? DWELL_TOP : RUN_DOWN;
                        end
                    end
                    RUN_DOWN: begin
                        if (pos_q != '0) pos_d = pos_q - 1'b1;
                        if (pos_d == '0) begin
                            end_d   = 1'b1;
                            state_d = (DWELL > 0) ? DWELL_BOT : RUN_UP;
                        end
                    end
                    default: begin
                        if (cnt_q + 1'b1 == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = (state_q == DWELL_TOP) ? RUN_DOWN : RUN_UP;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        leds_d = ONE_HOT0 << pos_d;
        dir_d  = (state_d == RUN_UP) || (state_d == DWELL_BOT);
    end

    assign o_leds = leds_q;
    assign o_pos  = pos_q;
    assign o_dir  = dir_q;
    assign o_end  = end_q;

endmodule

// File: tb/tb_led_walker.sv
// Directed bench for led_walker: three instances (4/no dwell, 4/dwell 2, 5/wrap)
// share stimulus; each vector names the instance whose outputs it checks.
module tb_led_walker;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_tick = 1'b0;
    logic i_en = 1'b0;
    logic i_bounce = 1'b0;

    logic [3:0] leds_a, leds_b;
    logic [4:0] leds_c;
    logic [1:0] pos_a, pos_b;
    logic [2:0] pos_c;
    logic dir_a, dir_b, dir_c, end_a, end_b, end_c;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    led_walker #(.N_LEDS(4), .DWELL(0)) u_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick), .i_en(i_en), .i_bounce(i_bounce),
        .o_leds(leds_a), .o_pos(pos_a), .o_dir(dir_a), .o_end(end_a));
    led_walker #(.N_LEDS(4), .DWELL(2)) u_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick), .i_en(i_en), .i_bounce(i_bounce),
        .o_leds(leds_b), .o_pos(pos_b), .o_dir(dir_b), .o_end(end_b));
    led_walker #(.N_LEDS(5), .DWELL(0)) u_c (
        .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick), .i_en(i_en), .i_bounce(i_bounce),
        .o_leds(leds_c), .o_pos(pos_c), .o_dir(dir_c), .o_end(end_c));

    typedef struct {
        string name;
        int    sel;
        bit    rst, tick, en, bounce;
        int    pos;
        bit    endp, dir;
    } vec_t;

    vec_t vq[$];

    task automatic step(input bit rst, input bit tick, input bit en, input bit bounce);
        i_rst = rst; i_tick = tick; i_en = en; i_bounce = bounce;
        @(posedge i_clk);
        #1;
    endtask

    task automatic cmp(input string name, input string field, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", name, field, act, exp);
        end
    endtask

    task automatic chk(input string name, input int sel, input int pos, input bit endp, input bit dir);
        int p, l, d, e;
        case (sel)
            0: begin p = int'(pos_a); l = int'(leds_a); d = int'(dir_a); e = int'(end_a); end
            1: begin p = int'(pos_b); l = int'(leds_b); d = int'(dir_b); e = int'(end_b); end
            default: begin p = int'(pos_c); l = int'(leds_c); d = int'(dir_c); e = int'(end_c); end
        endcase
        cmp(name, "pos", p, pos);
        cmp(name, "leds", l, 1 << pos);
        cmp(name, "end", e, int'(endp));
        cmp(name, "dir", d, int'(dir));
    endtask

    task automatic add(input string n, input int s, input bit r, input bit t, input bit en,
                       input bit b, input int p, input bit e, input bit d);
        vec_t v;
        v.name = n; v.sel = s; v.rst = r; v.tick = t; v.en = en; v.bounce = b;
        v.pos = p; v.endp = e; v.dir = d;
        vq.push_back(v);
    endtask

    initial begin
        // Reset with tick held high, observed on every instance
        add("rst_a", 0, 1, 1, 1, 1, 0, 0, 1);
        add("rst_b", 1, 1, 1, 1, 1, 0, 0, 1);
        add("rst_c", 2, 1, 1, 1, 0, 0, 0, 1);
        // Bounce, no dwell, N=4
        add("bnc1", 0, 0, 1, 1, 1, 1, 0, 1);
        add("bnc2", 0, 0, 1, 1, 1, 2, 0, 1);
        add("bnc3", 0, 0, 1, 1, 1, 3, 1, 0);
        add("bnc4", 0, 0, 1, 1, 1, 2, 0, 0);
        add("bnc5", 0, 0, 1, 1, 1, 1, 0, 0);
        add("bnc6", 0, 0, 1, 1, 1, 0, 1, 1);
        add("bnc7", 0, 0, 1, 1, 1, 1, 0, 1);
        add("bnc8", 0, 0, 1, 1, 1, 2, 0, 1);
        // Bounce with dwell 2, N=4
        add("dw_rst", 1, 1, 0, 1, 1, 0, 0, 1);
        add("dw1", 1, 0, 1, 1, 1, 1, 0, 1);
        add("dw2", 1, 0, 1, 1, 1, 2, 0, 1);
        add("dw3", 1, 0, 1, 1, 1, 3, 1, 0);
        add("dw4", 1, 0, 1, 1, 1, 3, 0, 0);
        add("dw5", 1, 0, 1, 1, 1, 3, 0, 0);
        add("dw6", 1, 0, 1, 1, 1, 2, 0, 0);
        add("dw7", 1, 0, 1, 1, 1, 1, 0, 0);
        add("dw8", 1, 0, 1, 1, 1, 0, 1, 1);
        add("dw9", 1, 0, 1, 1, 1, 0, 0, 1);
        add("dw10", 1, 0, 1, 1, 1, 0, 0, 1);
        add("dw11", 1, 0, 1, 1, 1, 1, 0, 1);
        // Wrap, N=5
        add("wr_rst", 2, 1, 0, 1, 0, 0, 0, 1);
        add("wr1", 2, 0, 1, 1, 0, 1, 0, 1);
        add("wr2", 2, 0, 1, 1, 0, 2, 0, 1);
        add("wr3", 2, 0, 1, 1, 0, 3, 0, 1);
        add("wr4", 2, 0, 1, 1, 0, 4, 0, 1);
        add("wr5", 2, 0, 1, 1, 0, 0, 1, 1);
        add("wr6", 2, 0, 1, 1, 0, 1, 0, 1);
        // Enable gating and idle cycles on the wrap instance
        add("en_off1", 2, 0, 1, 0, 0, 1, 0, 1);
        add("en_off2", 2, 0, 1, 0, 0, 1, 0, 1);
        add("en_off3", 2, 0, 1, 0, 0, 1, 0, 1);
        add("idle", 2, 0, 0, 1, 0, 1, 0, 1);
        add("en_on", 2, 0, 1, 1, 0, 2, 0, 1);
        add("after_en", 2, 0, 0, 1, 0, 2, 0, 1);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].tick, vq[i].en, vq[i].bounce);
            chk(vq[i].name, vq[i].sel, vq[i].pos, vq[i].endp, vq[i].dir);
        end

        // Mode switch out of DWELL_TOP after one dwell tick, then resume bouncing
        step(1, 0, 1, 1);
        step(0, 1, 1, 1); step(0, 1, 1, 1); step(0, 1, 1, 1);
        chk("ms_top", 1, 3, 1, 0);
        step(0, 1, 1, 1);
        chk("ms_dwell", 1, 3, 0, 0);
        step(0, 1, 1, 0);
        chk("ms_wrap", 1, 0, 1, 1);
        step(0, 1, 1, 1); step(0, 1, 1, 1);
        chk("ms_up2", 1, 2, 0, 1);
        step(0, 1, 1, 1);
        chk("ms_top2", 1, 3, 1, 0);
        step(0, 1, 1, 1);
        chk("ms_cnt1", 1, 3, 0, 0);
        step(0, 1, 1, 1);
        chk("ms_cnt2", 1, 3, 0, 0);
        step(0, 1, 1, 1);
        chk("ms_down", 1, 2, 0, 0);

        // Reset while in DWELL_TOP
        step(1, 0, 1, 1);
        step(0, 1, 1, 1); step(0, 1, 1, 1); step(0, 1, 1, 1);
        step(0, 1, 1, 1);
        chk("rd_dwell", 1, 3, 0, 0);
        step(1, 1, 1, 1);
        chk("rd_reset", 1, 0, 0, 1);
        step(0, 1, 1, 1);
        chk("rd_resume", 1, 1, 0, 1);

        // Wrap to the top, then switch to bounce: landing at the top without moving
        step(1, 0, 1, 0);
        step(0, 1, 1, 0); step(0, 1, 1, 0); step(0, 1, 1, 0);
        chk("land_wrap", 0, 3, 0, 1);
        step(0, 1, 1, 1);
        chk("land_top", 0, 3, 1, 0);
        step(0, 1, 1, 1);
        chk("land_down", 0, 2, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
